// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle 16-bit-ISA datapath: opcodes, FSM
// states, ALU control codes and instruction field positions.
package datapath_pkg;

    localparam int INSTR_W = 16;

    // Instruction field slices
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 9;
    localparam int RT_HI  = 8;
    localparam int RT_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;
    localparam int JF_HI  = 11;
    localparam int JF_LO  = 0;

    typedef enum logic [3:0] {
        OP_LD    = 4'h0,
        OP_ST    = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_INV   = 4'h4,
        OP_SHL   = 4'h5,
        OP_SHR   = 4'h6,
        OP_AND   = 4'h7,
        OP_OR    = 4'h8,
        OP_SLT   = 4'h9,
        OP_NOP_A = 4'hA,
        OP_BEQ   = 4'hB,
        OP_BNE   = 4'hC,
        OP_JMP   = 4'hD,
        OP_NOP_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_INV,
        ALU_SHL,
        ALU_SHR,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_t;

    // Register-to-register ops that finish through WB with ALUOut
    function automatic logic is_alu_op(input opcode_t op);
        return (op inside {OP_ADD, OP_SUB, OP_INV, OP_SHL, OP_SHR,
                           OP_AND, OP_OR, OP_SLT});
    endfunction

    // Maps an opcode to its ALU operation; non-ALU opcodes default to add
    function automatic alu_ctrl_t alu_ctrl(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_INV:  return ALU_INV;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Shared instruction/data memory port with valid/ready handshake.
interface multicycle_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_datapath_gpr_file.sv
// 8 x DATA_W general purpose registers: one write port, two async reads.
// Every register, including R0, is writable and clears on reset.
module gpr_file #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr_a,
    input  logic [2:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] w_regs [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            // Each register loads only when addressed by the write port
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (i_we && (i_waddr == 3'(gi))) begin
                    r_q <= i_wdata;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign o_rdata_a = w_regs[i_raddr_a];
    assign o_rdata_b = w_regs[i_raddr_b];
endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: FETCH/DECODE/EXEC/MEM/WB FSM over a shared memory
// port. Memory request outputs are registered; retire is decoded from the
// current state so it coincides with the cycle whose edge updates pc.
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    multicycle_datapath_if.master       mem,
    output logic [ADDR_W-1:0]           pc,
    output logic                        halted,
    output logic                        retire
);
    localparam int SH_W = $clog2(DATA_W);

    state_t              r_state;
    logic [INSTR_W-1:0]  r_ir;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_alu_out;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_halted;

    opcode_t             w_op;
    logic [2:0]          w_rs;
    logic [2:0]          w_rt;
    logic [2:0]          w_rd;
    logic [DATA_W-1:0]   w_imm;
    logic [ADDR_W-1:0]   w_pc_plus2;
    logic [ADDR_W-1:0]   w_br_target;
    logic [ADDR_W-1:0]   w_jmp_target;
    logic                w_taken;
    logic [DATA_W-1:0]   w_alu;
    logic [DATA_W-1:0]   w_ea_sum;
    logic [ADDR_W-1:0]   w_ea;
    logic                w_retire;
    logic [ADDR_W-1:0]   w_next_pc;
    logic                w_rf_we;
    logic [2:0]          w_rf_waddr;
    logic [DATA_W-1:0]   w_rf_wdata;
    logic [DATA_W-1:0]   w_rdata_a;
    logic [DATA_W-1:0]   w_rdata_b;

    assign w_op  = opcode_t'(r_ir[OP_HI:OP_LO]);
    assign w_rs  = r_ir[RS_HI:RS_LO];
    assign w_rt  = r_ir[RT_HI:RT_LO];
    assign w_rd  = r_ir[RD_HI:RD_LO];
    assign w_imm = {{(DATA_W-6){r_ir[IMM_HI]}}, r_ir[IMM_HI:IMM_LO]};

    assign w_pc_plus2   = r_pc + ADDR_W'(2);
    assign w_br_target  = w_pc_plus2 + {{(ADDR_W-7){r_ir[IMM_HI]}}, r_ir[IMM_HI:IMM_LO], 1'b0};
    assign w_jmp_target = {w_pc_plus2[ADDR_W-1:13], r_ir[JF_HI:JF_LO], 1'b0};
    assign w_taken      = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

    // Effective address is computed at data width, then fitted to the bus
    assign w_ea_sum = r_a + w_imm;
    generate
        if (ADDR_W <= DATA_W) begin : g_ea_trunc
            assign w_ea = w_ea_sum[ADDR_W-1:0];
        end else begin : g_ea_ext
            assign w_ea = {{(ADDR_W-DATA_W){1'b0}}, w_ea_sum};
        end
    endgenerate

    // ALU on the operand latches captured in DECODE
    always_comb begin
        w_alu = '0;
        case (alu_ctrl(w_op))
            ALU_ADD: w_alu = r_a + r_b;
            ALU_SUB: w_alu = r_a - r_b;
            ALU_INV: w_alu = ~r_a;
            ALU_SHL: w_alu = r_a << r_b[SH_W-1:0];
            ALU_SHR: w_alu = r_a >> r_b[SH_W-1:0];
            ALU_AND: w_alu = r_a & r_b;
            ALU_OR:  w_alu = r_a | r_b;
            ALU_SLT: w_alu = DATA_W'($signed(r_a) < $signed(r_b));
            default: w_alu = '0;
        endcase
    end

    // Last cycle of each instruction and the pc it hands to the next fetch
    always_comb begin
        w_retire  = 1'b0;
        w_next_pc = w_pc_plus2;
        case (r_state)
            EXEC: begin
                case (w_op)
                    OP_BEQ, OP_BNE: begin
                        w_retire  = 1'b1;
                        w_next_pc = w_taken ? w_br_target : w_pc_plus2;
                    end
                    OP_JMP: begin
                        w_retire  = 1'b1;
                        w_next_pc = w_jmp_target;
                    end
                    OP_NOP_A, OP_NOP_E: w_retire = 1'b1;
                    default: ;
                endcase
            end
            MEM:     w_retire = (w_op == OP_ST) && mem.mem_ready;
            WB:      w_retire = 1'b1;
            default: ;
        endcase
    end

    // Writeback: loads target rt, ALU ops target rd; suppressed under reset
    assign w_rf_we    = (r_state == WB) && rst_n;
    assign w_rf_waddr = (w_op == OP_LD) ? w_rt : w_rd;
    assign w_rf_wdata = (w_op == OP_LD) ? r_mdr : r_alu_out;

    gpr_file #(.DATA_W(DATA_W)) u_gpr_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    // Control FSM with registered memory-port outputs and architectural state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc        <= ADDR_W'(RESET_PC);
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu_out   <= '0;
            r_mdr       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_halted    <= 1'b0;
        end else if (w_retire) begin
            // Fetch of the next instruction is issued on the retire edge so
            // it costs no extra cycle; run only gates this request.
            r_pc       <= w_next_pc;
            r_state    <= FETCH;
            r_mem_req  <= run;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_next_pc;
        end else begin
            case (r_state)
                FETCH: begin
                    if (r_mem_req && mem.mem_ready) begin
                        r_ir      <= mem.mem_rdata[INSTR_W-1:0];
                        r_mem_req <= 1'b0;
                        r_state   <= DECODE;
                    end else if (!r_mem_req && run) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                    end
                end
                DECODE: begin
                    r_a     <= w_rdata_a;
                    r_b     <= w_rdata_b;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (is_alu_op(w_op)) begin
                        r_alu_out <= w_alu;
                        r_state   <= WB;
                    end else if ((w_op == OP_LD) || (w_op == OP_ST)) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_op == OP_ST);
                        r_mem_addr  <= w_ea;
                        r_mem_wdata <= r_b;
                        r_state     <= MEM;
                    end else if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end
                end
                MEM: begin
                    if (mem.mem_ready && (w_op == OP_LD)) begin
                        r_mdr     <= mem.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= WB;
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign pc            = r_pc;
    assign halted        = r_halted;
    assign retire        = w_retire;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: runs a small program from a
// behavioural memory and checks timing, pc flow and stored results.
module tb_multicycle_datapath;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              retire;

    multicycle_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

    multicycle_datapath #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0040)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .mem    (mif),
        .pc     (pc),
        .halted (halted),
        .retire (retire)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory with per-address wait states
    logic [15:0] mem_arr [0:32767];
    logic [15:0] wait_addr;
    int          wait_cfg;
    int          wait_cnt;
    int          wr_count;
    logic        hs;

    assign mif.mem_rdata = mem_arr[mif.mem_addr[15:1]];

    always @(posedge clk) begin
        hs = mif.mem_req && mif.mem_ready;
        if (hs && mif.mem_we) begin
            mem_arr[mif.mem_addr[15:1]] = mif.mem_wdata;
            wr_count++;
        end
        #1;
        if (hs) wait_cnt = 0;
        if (!mif.mem_req) begin
            mif.mem_ready = 1'b0;
            wait_cnt      = 0;
        end else if (mif.mem_addr != wait_addr || wait_cnt >= wait_cfg) begin
            mif.mem_ready = 1'b1;
        end else begin
            mif.mem_ready = 1'b0;
            wait_cnt++;
        end
    end

    int n_checks;
    int n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [5:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [2:0] rd);
        return {op, rs, rt, rd, 3'b000};
    endfunction

    function automatic logic [15:0] enc_j(input logic [11:0] field);
        return {4'hD, field};
    endfunction

    // Values seen on the memory port in the retire cycle of the last step
    logic        ret_we;
    logic [15:0] ret_addr;
    logic [15:0] ret_wdata;

    // Runs one instruction from its fetch cycle to its retire pulse.
    // Called at the negedge just before the fetch cycle.
    task automatic step(input string tag, input int exp_cyc, input logic [15:0] exp_pc);
        int          cyc;
        logic        got_ret;
        logic        prev_wait;
        logic [15:0] p_addr;
        logic [15:0] p_wdata;
        cyc       = 0;
        got_ret   = 1'b0;
        prev_wait = 1'b0;
        p_addr    = '0;
        p_wdata   = '0;
        while (cyc < 40 && !got_ret) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_val({tag, " pc"}, 32'(pc), 32'(exp_pc));
                check_val({tag, " fetch_req"}, 32'(mif.mem_req), 32'd1);
                check_val({tag, " fetch_addr"}, 32'(mif.mem_addr), 32'(exp_pc));
            end
            if (prev_wait) begin
                check_val({tag, " hold_req"}, 32'(mif.mem_req), 32'd1);
                check_val({tag, " hold_addr"}, 32'(mif.mem_addr), 32'(p_addr));
                check_val({tag, " hold_wdata"}, 32'(mif.mem_wdata), 32'(p_wdata));
            end
            prev_wait = mif.mem_req && !mif.mem_ready;
            p_addr    = mif.mem_addr;
            p_wdata   = mif.mem_wdata;
            got_ret   = retire;
        end
        ret_we    = mif.mem_req && mif.mem_ready && mif.mem_we;
        ret_addr  = mif.mem_addr;
        ret_wdata = mif.mem_wdata;
        check_val({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic check_store(input string tag, input logic [15:0] addr, input logic [15:0] data);
        check_val({tag, " we"}, 32'(ret_we), 32'd1);
        check_val({tag, " addr"}, 32'(ret_addr), 32'(addr));
        check_val({tag, " data"}, 32'(ret_wdata), 32'(data));
    endtask

    initial begin
        int n_req;
        int n_ret;
        n_checks      = 0;
        n_errors      = 0;
        wr_count      = 0;
        wait_cnt      = 0;
        wait_cfg      = 0;
        wait_addr     = 16'hFFFF;
        mif.mem_ready = 1'b0;
        rst_n         = 1'b0;
        run           = 1'b0;
        for (int i = 0; i < 32768; i++) mem_arr[i] = 16'h0000;

        // Data
        mem_arr[16'h10 >> 1] = 16'd5;
        mem_arr[16'h12 >> 1] = 16'd3;
        // Program at reset pc 0x40
        mem_arr[16'h40 >> 1] = enc_i(4'h0, 3'd0, 3'd1, 6'h10);   // LD  R1, 0x10(R0)
        mem_arr[16'h42 >> 1] = enc_i(4'h0, 3'd0, 3'd2, 6'h12);   // LD  R2, 0x12(R0)
        mem_arr[16'h44 >> 1] = enc_r(4'h2, 3'd1, 3'd2, 3'd3);    // ADD R3 = R1+R2
        mem_arr[16'h46 >> 1] = enc_r(4'h3, 3'd1, 3'd2, 3'd4);    // SUB R4 = R1-R2
        mem_arr[16'h48 >> 1] = enc_r(4'h9, 3'd2, 3'd1, 3'd5);    // SLT R5 = R2<R1
        mem_arr[16'h4A >> 1] = enc_r(4'h4, 3'd1, 3'd0, 3'd6);    // INV R6 = ~R1
        mem_arr[16'h4C >> 1] = enc_r(4'h5, 3'd1, 3'd2, 3'd7);    // SHL R7 = R1<<R2
        mem_arr[16'h4E >> 1] = enc_i(4'h1, 3'd0, 3'd3, 6'h18);   // ST  R3 -> 0x18
        mem_arr[16'h50 >> 1] = enc_i(4'h1, 3'd0, 3'd4, 6'h1A);   // ST  R4 -> 0x1A
        mem_arr[16'h52 >> 1] = enc_i(4'h1, 3'd0, 3'd6, 6'h16);   // ST  R6 -> 0x16
        mem_arr[16'h54 >> 1] = enc_i(4'h1, 3'd0, 3'd7, 6'h14);   // ST  R7 -> 0x14
        mem_arr[16'h56 >> 1] = enc_i(4'h1, 3'd0, 3'd5, 6'h1C);   // ST  R5 -> 0x1C (waits)
        mem_arr[16'h58 >> 1] = 16'hA000;                         // NOP
        mem_arr[16'h5A >> 1] = enc_j(12'h010);                   // JMP 0x0020
        mem_arr[16'h20 >> 1] = enc_i(4'hB, 3'd1, 3'd1, 6'h3E);   // BEQ equal, -2
        mem_arr[16'h1E >> 1] = enc_i(4'hC, 3'd1, 3'd2, 6'h02);   // BNE unequal, +2
        mem_arr[16'h24 >> 1] = enc_i(4'hC, 3'd1, 3'd1, 6'h3E);   // BNE equal
        mem_arr[16'h26 >> 1] = enc_i(4'hB, 3'd1, 3'd2, 6'h05);   // BEQ unequal
        mem_arr[16'h28 >> 1] = enc_j(12'hFFF);                   // JMP 0x1FFE
        mem_arr[16'h1FFE >> 1] = enc_j(12'h123);                 // JMP 0x2246
        mem_arr[16'h2246 >> 1] = 16'hF000;                       // HALT

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst pc", 32'(pc), 32'h40);
        check_val("rst mem_req", 32'(mif.mem_req), 32'd0);
        check_val("rst mem_we", 32'(mif.mem_we), 32'd0);
        check_val("rst mem_addr", 32'(mif.mem_addr), 32'd0);
        check_val("rst mem_wdata", 32'(mif.mem_wdata), 32'd0);
        check_val("rst halted", 32'(halted), 32'd0);
        check_val("rst retire", 32'(retire), 32'd0);

        // run low: no request
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_val("run_low mem_req", 32'(mif.mem_req), 32'd0);
        end
        run = 1'b1;

        step("ld_r1", 5, 16'h40);
        step("ld_r2", 5, 16'h42);
        step("add", 4, 16'h44);
        step("sub", 4, 16'h46);
        step("slt", 4, 16'h48);
        step("inv", 4, 16'h4A);
        step("shl", 4, 16'h4C);
        step("st_add", 4, 16'h4E);
        check_store("st_add", 16'h18, 16'd8);
        step("st_sub", 4, 16'h50);
        check_store("st_sub", 16'h1A, 16'd2);
        step("st_inv", 4, 16'h52);
        check_store("st_inv", 16'h16, 16'hFFFA);
        step("st_shl", 4, 16'h54);
        check_store("st_shl", 16'h14, 16'h0028);
        wait_addr = 16'h1C;
        wait_cfg  = 3;
        step("st_wait", 7, 16'h56);
        check_store("st_wait", 16'h1C, 16'd1);
        wait_addr = 16'hFFFF;
        step("nop", 3, 16'h58);
        step("jmp_lo", 3, 16'h5A);
        step("beq_taken", 3, 16'h20);
        step("bne_taken", 3, 16'h1E);
        step("bne_not", 3, 16'h24);
        step("beq_not", 3, 16'h26);
        step("jmp_fff", 3, 16'h28);
        step("jmp_page", 3, 16'h1FFE);

        // HALT: no retire, no further requests, pc frozen
        @(negedge clk);
        check_val("halt_fetch pc", 32'(pc), 32'h2246);
        n_req = 0;
        n_ret = 0;
        repeat (12) begin
            @(negedge clk);
            n_req += int'(mif.mem_req);
            n_ret += int'(retire);
        end
        check_val("halt halted", 32'(halted), 32'd1);
        check_val("halt pc", 32'(pc), 32'h2246);
        check_val("halt req_count", 32'(n_req), 32'd0);
        check_val("halt retire_count", 32'(n_ret), 32'd0);
        check_val("mem 0x18", 32'(mem_arr[16'h18 >> 1]), 32'd8);
        check_val("mem 0x1C", 32'(mem_arr[16'h1C >> 1]), 32'd1);
        check_val("write_count", 32'(wr_count), 32'd5);

        // Reset leaves HALT; then reset again in the middle of a stalled LD
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst2 pc", 32'(pc), 32'h40);
        check_val("rst2 halted", 32'(halted), 32'd0);
        wait_addr = 16'h10;
        wait_cfg  = 1000;
        rst_n     = 1'b1;
        repeat (6) @(negedge clk);
        check_val("ld_stall mem_req", 32'(mif.mem_req), 32'd1);
        check_val("ld_stall mem_addr", 32'(mif.mem_addr), 32'h10);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("ld_abort mem_req", 32'(mif.mem_req), 32'd0);
        check_val("ld_abort pc", 32'(pc), 32'h40);
        wait_addr = 16'hFFFF;
        mem_arr[16'h40 >> 1] = enc_i(4'h1, 3'd0, 3'd1, 6'h14);   // ST R1 -> 0x14
        @(negedge clk);
        rst_n = 1'b1;
        step("st_r1", 4, 16'h40);
        check_store("st_r1", 16'h14, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
